// File: rtl/cpu4_pkg.sv
// Shared encodings for the 4-bit microcontroller: opcode classes, register
// codes, control-word bit positions and sequencer state.
package cpu4_pkg;

    // Instruction-register value used as a bubble after reset and on flush
    localparam logic [7:0] NOP_IR = 8'hFF;

    // Jump opcodes (1110_00kk), each followed by an address byte
    localparam logic [7:0] OP_JMP = 8'hE0;
    localparam logic [7:0] OP_JZ  = 8'hE1;
    localparam logic [7:0] OP_JNZ = 8'hE2;

    // Destination encoding (LOAD/MOVE dst field)
    localparam logic [2:0] DST_X0 = 3'd0;
    localparam logic [2:0] DST_X1 = 3'd1;
    localparam logic [2:0] DST_Y0 = 3'd2;
    localparam logic [2:0] DST_Y1 = 3'd3;
    localparam logic [2:0] DST_O  = 3'd4;
    localparam logic [2:0] DST_M  = 3'd5;
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    // Source encoding (MOVE src field); only r differs from dst encoding
    localparam logic [2:0] SRC_R  = 3'd4;
    localparam logic [2:0] SRC_DM = 3'd7;

    // reg_en bit positions
    localparam int RE_X0 = 0;
    localparam int RE_X1 = 1;
    localparam int RE_Y0 = 2;
    localparam int RE_Y1 = 3;
    localparam int RE_R  = 4;
    localparam int RE_M  = 5;
    localparam int RE_I  = 6;
    localparam int RE_DM = 7;
    localparam int RE_O  = 8;

    // data_bus source_sel codes beyond the 0..7 register sources
    localparam logic [3:0] SS_PM   = 4'd8;
    localparam logic [3:0] SS_PINS = 4'd9;
    localparam logic [3:0] SS_ZERO = 4'd10;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef enum logic [1:0] {
        JK_JMP  = 2'd0,
        JK_JZ   = 2'd1,
        JK_JNZ  = 2'd2,
        JK_NONE = 2'd3
    } jump_kind_t;

    // One-hot write enable for a LOAD/MOVE destination code
    function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
        logic [8:0] oh;
        oh = '0;
        case (dst)
            DST_X0:  oh[RE_X0] = 1'b1;
            DST_X1:  oh[RE_X1] = 1'b1;
            DST_Y0:  oh[RE_Y0] = 1'b1;
            DST_Y1:  oh[RE_Y1] = 1'b1;
            DST_O:   oh[RE_O]  = 1'b1;
            DST_M:   oh[RE_M]  = 1'b1;
            DST_I:   oh[RE_I]  = 1'b1;
            default: oh[RE_DM] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure combinational decode of the instruction register into the control
// word for the computational unit, plus jump classification for the sequencer.
module instr_decode
    import cpu4_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       is_jump,
    output logic [1:0] jump_kind
);

    logic [2:0] dst;
    logic [2:0] src;
    logic       has_dst;
    logic       auto_inc;

    // Classify ir, then apply destination enable and dm post-increment of i
    always_comb begin
        source_sel = SS_ZERO;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        is_jump    = 1'b0;
        jump_kind  = JK_NONE;
        dst        = ir[6:4];
        src        = ir[2:0];
        has_dst    = 1'b0;
        auto_inc   = 1'b0;

        if (!ir[7]) begin
            // LOAD 0ddd_nnnn
            has_dst    = 1'b1;
            dst        = ir[6:4];
            source_sel = SS_PM;
            auto_inc   = (dst == DST_DM);
        end else if (ir[7:6] == 2'b10) begin
            // MOVE 10dd_dsss; src==dst selects the input pins instead
            has_dst    = 1'b1;
            dst        = ir[5:3];
            source_sel = (src == dst) ? SS_PINS : {1'b0, src};
            auto_inc   = (dst == DST_DM) || (src == SRC_DM);
        end else if (ir[7:5] == 3'b110) begin
            // ALU 110x_yfff; fff 000/111 with y set is a no-op
            x_sel = ir[4];
            y_sel = ir[3];
            if (!(ir[3] && (ir[2:0] == 3'b000 || ir[2:0] == 3'b111)))
                reg_en[RE_R] = 1'b1;
        end else if (ir == OP_JMP || ir == OP_JZ || ir == OP_JNZ) begin
            is_jump   = 1'b1;
            jump_kind = ir[1:0];
        end

        if (has_dst) begin
            reg_en = reg_en | dst_onehot(dst);
            if (dst == DST_I) begin
                i_sel = 1'b0;
            end else if (auto_inc) begin
                reg_en[RE_I] = 1'b1;
                i_sel        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches bytes from program memory into ir, resolves
// two-byte jumps against r_eq_0, and drives the decoded control word.
module instr_sequencer
    import cpu4_pkg::*;
#(
    parameter int         PC_W   = 8,
    parameter logic [7:0] NOP_IR = cpu4_pkg::NOP_IR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            hold,
    input  logic [7:0]      pm_data,
    input  logic            r_eq_0,
    output logic [PC_W-1:0] pm_address,
    output logic [7:0]      ir,
    output logic [3:0]      nibble_ir,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic            dbg_state
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [7:0]      ir_nxt;
    logic [8:0]      dec_reg_en;
    logic            is_jump;
    logic [1:0]      jump_kind;
    logic            taken;

    instr_decode u_decode (
        .ir         (ir),
        .source_sel (source_sel),
        .reg_en     (dec_reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .is_jump    (is_jump),
        .jump_kind  (jump_kind)
    );

    // Jump condition is evaluated in the cycle the jump sits in ir
    always_comb begin
        taken = 1'b0;
        case (jump_kind)
            JK_JMP:  taken = 1'b1;
            JK_JZ:   taken = r_eq_0;
            JK_JNZ:  taken = !r_eq_0;
            default: taken = 1'b0;
        endcase
    end

    // Next pc/ir/state; hold freezes everything
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        if (!hold) begin
            case (state)
                ST_RUN: begin
                    if (is_jump) begin
                        // pm_data is the address byte; bubble the pipeline
                        pc_nxt    = taken ? pm_data : pc + PC_W'(1);
                        ir_nxt    = NOP_IR;
                        state_nxt = ST_FLUSH;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                        ir_nxt = pm_data;
                    end
                end
                default: begin
                    pc_nxt    = pc + PC_W'(1);
                    ir_nxt    = pm_data;
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer registers, async reset to a NOP at address 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
            pc    <= '0;
            ir    <= NOP_IR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // No register writes while frozen
    always_comb begin
        reg_en = hold ? 9'd0 : dec_reg_en;
    end

    assign pm_address = pc;
    assign nibble_ir  = ir[3:0];
    assign dbg_state  = state;

endmodule
